// File: rtl/bus_pkg.sv
// Shared types for the system-bus arbiter: FSM states, owner encoding,
// hold-counter width and the contention arbitration rule.
package bus_pkg;

  localparam int ARB_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    DMA_OWN = 2'd2,
    TURN    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

  // Winner of an arbitration slot; under contention the side that did not
  // own the bus last gets it, so ownership alternates.
  function automatic arb_state_t arb_pick(input logic cpu_req, input logic dma_req,
                                          input owner_t last);
    arb_state_t pick;
    pick = IDLE;
    if (cpu_req && dma_req) pick = (last == OWNER_CPU) ? DMA_OWN : CPU_OWN;
    else if (cpu_req)       pick = CPU_OWN;
    else if (dma_req)       pick = DMA_OWN;
    return pick;
  endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Request/grant handshake between the two bus requesters and the arbiter.
// master: requester side (CPU sequencer + DMA mover), slave: arbiter side.
interface sysbus_arbiter_if;
  logic cpu_req;
  logic cpu_done;
  logic dma_req;
  logic dma_done;
  logic err_clr;
  logic cpu_gnt;
  logic dma_gnt;
  logic bus_idle;
  logic last_owner;
  logic timeout_err;

  modport master (
    output cpu_req, cpu_done, dma_req, dma_done, err_clr,
    input  cpu_gnt, dma_gnt, bus_idle, last_owner, timeout_err
  );

  modport slave (
    input  cpu_req, cpu_done, dma_req, dma_done, err_clr,
    output cpu_gnt, dma_gnt, bus_idle, last_owner, timeout_err
  );
endinterface

// File: rtl/hold_timer.sv
// Ownership watchdog: counts owned cycles and flags the cycle in which the
// count would reach HOLD_MAX, so the grant lasts exactly HOLD_MAX cycles.
module hold_timer
  import bus_pkg::*;
#(
  parameter int HOLD_MAX = 63
) (
  input  logic clock,
  input  logic n_reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [ARB_CNT_W-1:0] LAST_CNT = ARB_CNT_W'(HOLD_MAX - 1);

  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;

  // Zero outside ownership, one step per owned cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (!n_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expire_o = inc_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/sysbus_arbiter.sv
// Two-requester sysbus arbiter with a no-driver turnaround gap on every
// handover. Optional hold watchdog enabled by SYSBUS_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner, arbitrate every cycle
// CPU_OWN | CPU sequencer drives sysbus
// DMA_OWN | DMA mover drives sysbus
// TURN    | TURN_CYC cycles with no driver; last cycle arbitrates
module sysbus_arbiter
  import bus_pkg::*;
#(
  parameter int HOLD_MAX = 63,
  parameter int TURN_CYC = 1
) (
  input logic             clock,
  input logic             n_reset,
  sysbus_arbiter_if.slave bus
);

  localparam logic [2:0] TURN_LOAD = 3'(TURN_CYC - 1);

  arb_state_t state_q, state_d;
  owner_t     last_owner_q, last_owner_d;
  logic [2:0] turn_cnt_q, turn_cnt_d;
  logic       timeout_err_q, timeout_err_d;
  logic       own_cpu, own_dma, release_own, expire;

  assign own_cpu     = (state_q == CPU_OWN);
  assign own_dma     = (state_q == DMA_OWN);
  assign release_own = (own_cpu && (bus.cpu_done || !bus.cpu_req)) ||
                       (own_dma && (bus.dma_done || !bus.dma_req));

`ifdef SYSBUS_ARB_TIMEOUT_EN
  hold_timer #(.HOLD_MAX(HOLD_MAX)) u_hold_timer (
    .clock    (clock),
    .n_reset  (n_reset),
    .clr_i    (!(own_cpu || own_dma)),
    .inc_i    (own_cpu || own_dma),
    .expire_o (expire)
  );

  // Sticky watchdog flag; a new revoke beats a simultaneous clear.
  always_comb begin
    timeout_err_d = timeout_err_q;
    if (expire && !release_own) timeout_err_d = 1'b1;
    else if (bus.err_clr)       timeout_err_d = 1'b0;
  end
`else
  logic unused_cfg;
  assign unused_cfg    = bus.err_clr ^ HOLD_MAX[0];
  assign expire        = 1'b0;
  assign timeout_err_d = 1'b0;
`endif

  // Next state and turnaround down-counter.
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    case (state_q)
      IDLE: state_d = arb_pick(bus.cpu_req, bus.dma_req, last_owner_q);
      CPU_OWN, DMA_OWN: begin
        if (release_own || expire) begin
          state_d    = TURN;
          turn_cnt_d = TURN_LOAD;
        end
      end
      TURN: begin
        if (turn_cnt_q == '0) state_d = arb_pick(bus.cpu_req, bus.dma_req, last_owner_q);
        else                  turn_cnt_d = turn_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Remember whoever is being granted; a revoked owner stays recorded.
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_d == CPU_OWN)      last_owner_d = OWNER_CPU;
    else if (state_d == DMA_OWN) last_owner_d = OWNER_DMA;
  end

  // State registers; reset drops any grant without a turnaround.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q       <= IDLE;
      last_owner_q  <= OWNER_DMA;
      turn_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      turn_cnt_q    <= turn_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.cpu_gnt     = own_cpu;
  assign bus.dma_gnt     = own_dma;
  assign bus.bus_idle    = (state_q == IDLE) || (state_q == TURN);
  assign bus.last_owner  = last_owner_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
